dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
- Load/store access controller directly upstream of the word-only data memory.
- Accepts one memory operation at a time from the pipeline MEM stage: lw/lh/lhu/lb/lbu/sw/sh/sb.
- Converts each operation into word reads and writes on the data memory port. Sub-word stores use read-modify-write. Loads return sign- or zero-extended data.
- Detects misaligned and out-of-range addresses, and stalls the pipeline until the operation completes.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in the data memory; word index is Addr[11:2] at default.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Req  in  1  memory operation request; held stable with all other inputs while Stall=1.
- MemOp  in  3  operation: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- Addr  in  32  byte address.
- WData  in  32  store data; the low byte or low half is used for sb/sh.
- PC  in  32  PC of the requesting instruction.
- Stall  out  1  pipeline hold.
- Done  out  1  one-cycle completion pulse.
- RData  out  32  load result, valid while Done=1.
- AdEL  out  1  load address fault, valid while Done=1.
- AdES  out  1  store address fault, valid while Done=1.
- DMWr  out  1  data memory write enable.
- DmA  out  32  data memory word address, always {addr_q[31:2],2'b00}.
- DmWD  out  32  data memory write data.
- DmPC  out  32  latched PC forwarded to data memory.
- DmD  in  32  data memory read data, combinational from DmA.

Behaviour:
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- Reset asserted (any time, including mid-operation): state=IDLE immediately; op_q/addr_q/wdata_q/PC_q=0; RData=0, AdEL=AdES=0. DMWr=0 immediately, since DMWr is decoded from state.
- Stall = Req & ~Done (combinational).
- Done = (state==RESP).
- DMWr = (state==WRITE).
- IDLE:
  - If Req=1, latch MemOp, Addr, WData and PC.
  - Fault check: lw/sw with Addr[1:0]!=0, or lh/lhu/sh with Addr[0]!=0. A faulting operation goes to RESP with AdEL (loads) or AdES (stores) set, RData=0, and no DM access.
  - Otherwise: loads go to LOAD, sw goes to WRITE, sh/sb go to MERGE.
- LOAD:
  - Select from DmD using addr_q[1:0], little-endian: byte k = bits[8k+7:8k]; halfword at offset 0 or 2.
  - Sign-extend for lb/lh; zero-extend for lbu/lhu; lw passes the word through.
  - Register the result into RData, then go to RESP.
- MERGE:
  - Capture DmD into merge_q.
  - Replace the addressed byte (sb) or halfword (sh) with wdata_q[7:0] or wdata_q[15:0].
  - Go to WRITE.
- WRITE:
  - DmWD = merge_q for sh/sb, wdata_q for sw.
  - Go to RESP.
- RESP:
  - Hold RData/AdEL/AdES for one cycle.
  - Always go to IDLE; never accepts a request in this cycle.
  - RData and fault flags clear to 0 on leaving RESP.
- Latency (Req sampled at edge 0; Done high in the cycle after that many edges):
  - Loads: 2.
  - sw: 2.
  - sh/sb: 3.
  - Faults: 1.
- Back-to-back requests: the new request is accepted in the IDLE cycle after RESP.
- Req dropping mid-operation is ignored; the operation completes on latched values.
- Req=0 in IDLE: no state change and no DM access.

Optional Feature:
- Macro: DM_ACCESS_RANGE_CHECK_EN.
- Defined: additionally fault when Addr[31:2] >= DM_WORDS. AdEL for loads, AdES for stores, same 1-cycle RESP path, no DM access.
- Undefined: no range check; upper address bits pass to DmA unchanged, and the memory wraps on its index bits.

Test Plan:
- DM word 0x10 = 0x8070F0A5; lb Addr=0x12 -> Done at cycle 2, RData=0x00000070. Then lb Addr=0x13 -> RData=0xFFFFFF80. Then lbu Addr=0x10 -> RData=0x000000A5.
- DM word 0x10 = 0x11223344; sh Addr=0x12, WData=0xDEADBEEF -> one DMWr pulse in the WRITE cycle, DmWD=0xBEEF3344; Done at cycle 3.
- sw Addr=0x4, WData=0xCAFEF00D -> DMWr=1 in cycle 1, DmA=0x4; then lw Addr=0x4 -> RData=0xCAFEF00D.
- lw Addr=0x6 -> AdEL=1, Done at cycle 1, DMWr never asserted. sh Addr=0x3 -> AdES=1.
- Reset driven low during the WRITE state of an sb -> DMWr drops to 0 in the same cycle; state=IDLE; Stall deasserts once Req is low.
- With DM_ACCESS_RANGE_CHECK_EN: lw Addr=0x1000 -> AdEL=1. Without it: lw Addr=0x1000 -> RData = contents of word 0x0.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Bus between the MEM-stage pipeline, the access controller and the word-only data memory.
// The slave modport is the controller's view; master is the pipeline/memory side.
interface dm_access_ctrl_if;
    // Pipeline request side
    logic        Req;
    logic [2:0]  MemOp;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] PC;
    logic        Stall;
    logic        Done;
    logic [31:0] RData;
    logic        AdEL;
    logic        AdES;
    // Data memory side
    logic        DMWr;
    logic [31:0] DmA;
    logic [31:0] DmWD;
    logic [31:0] DmPC;
    logic [31:0] DmD;

    modport slave (
        input  Req, MemOp, Addr, WData, PC, DmD,
        output Stall, Done, RData, AdEL, AdES, DMWr, DmA, DmWD, DmPC
    );

    modport master (
        output Req, MemOp, Addr, WData, PC, DmD,
        input  Stall, Done, RData, AdEL, AdES, DMWr, DmA, DmWD, DmPC
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store access controller in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
// Optional macro DM_ACCESS_RANGE_CHECK_EN adds an out-of-range address fault
// (word index >= DM_WORDS); without it upper address bits pass through and the memory wraps.
module dm_access_ctrl #(
    parameter int unsigned DM_WORDS = 1024
) (
    input logic              CLK,
    input logic              Reset,
    dm_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        OpLw  = 3'b000,
        OpLh  = 3'b001,
        OpLhu = 3'b010,
        OpLb  = 3'b011,
        OpLbu = 3'b100,
        OpSw  = 3'b101,
        OpSh  = 3'b110,
        OpSb  = 3'b111
    } mem_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMerge,
        StWrite,
        StResp
    } state_e;

    state_e      state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic [31:0] merge_q, merge_d;

    mem_op_e     req_op;
    logic        req_is_store;
    logic        misalign_fault;
    logic        range_fault;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_op       = mem_op_e'(bus.MemOp);
    assign req_is_store = bus.MemOp[2] & (bus.MemOp[1] | bus.MemOp[0]);

    // Alignment fault on the incoming request
    always_comb begin
        misalign_fault = 1'b0;
        case (req_op)
            OpLw, OpSw:        misalign_fault = (bus.Addr[1:0] != 2'b00);
            OpLh, OpLhu, OpSh: misalign_fault = bus.Addr[0];
            default:           misalign_fault = 1'b0;
        endcase
    end

`ifdef DM_ACCESS_RANGE_CHECK_EN
    assign range_fault = ({2'b00, bus.Addr[31:2]} >= DM_WORDS);
`else
    // Memory wraps on its index bits; DM_WORDS only matters when range checking.
    logic unused_dm_words;
    assign unused_dm_words = ^DM_WORDS;
    assign range_fault     = 1'b0;
`endif

    assign req_fault = misalign_fault | range_fault;

    // Lane select and extension of the returned memory word (little-endian)
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        ld_byte = bus.DmD[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.DmD[31:16] : bus.DmD[15:0];
        case (op_q)
            OpLb:    load_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   load_data = {24'h000000, ld_byte};
            OpLh:    load_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   load_data = {16'h0000, ld_half};
            default: load_data = bus.DmD;
        endcase
    end

    // Splice the store byte/halfword into the word read back from memory
    always_comb begin
        merged_word = bus.DmD;
        if (op_q == OpSb) begin
            merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and registered-output logic for the access sequence
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        adel_d  = adel_q;
        ades_d  = ades_q;
        merge_d = merge_q;
        case (state_q)
            StIdle: begin
                if (bus.Req) begin
                    op_d    = req_op;
                    addr_d  = bus.Addr;
                    wdata_d = bus.WData;
                    pc_d    = bus.PC;
                    if (req_fault) begin
                        // Faulting ops skip the memory entirely
                        adel_d  = ~req_is_store;
                        ades_d  = req_is_store;
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else if (!req_is_store) begin
                        state_d = StLoad;
                    end else if (req_op == OpSw) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StMerge;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_data;
                state_d = StResp;
            end
            StMerge: begin
                merge_d = merged_word;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                // Response is a one-cycle pulse; clear results on the way out
                rdata_d = 32'h0;
                adel_d  = 1'b0;
                ades_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            op_q    <= OpLw;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
            merge_q <= merge_d;
        end
    end

    assign bus.Done  = (state_q == StResp);
    assign bus.Stall = bus.Req & ~bus.Done;
    assign bus.DMWr  = (state_q == StWrite);
    assign bus.DmA   = {addr_q[31:2], 2'b00};
    assign bus.DmWD  = (op_q == OpSw) ? wdata_q : merge_q;
    assign bus.DmPC  = pc_q;
    assign bus.RData = rdata_q;
    assign bus.AdEL  = adel_q;
    assign bus.AdES  = ades_q;

endmodule
